// File: rtl/lane_clk_ctrl_if.sv
// Request/transmit/divider-control bundle between link/config logic and lane_clk_ctrl.
// The master side is the link/config logic. The slave side is the controller.
interface lane_clk_ctrl_if;
    logic req_valid;
    logic req_ready;
    logic req_single_lane;
    logic tx_idle;
    logic tx_enable;
    logic single_lane;
    logic div_rst_n;
    logic busy;
    logic done;
    logic timeout;

    modport master (
        output req_valid, req_single_lane, tx_idle,
        input  req_ready, tx_enable, single_lane, div_rst_n, busy, done, timeout
    );

    modport slave (
        input  req_valid, req_single_lane, tx_idle,
        output req_ready, tx_enable, single_lane, div_rst_n, busy, done, timeout
    );
endinterface

// File: rtl/lane_clk_ctrl.sv
// Lane clock divider reconfiguration sequencer. It quiesces TX, holds the divider
// in reset across a mode change, waits for the clock to settle, then re-enables TX.
module lane_clk_ctrl #(
    parameter bit          RESET_SINGLE_LANE = 1'b1,
    parameter int unsigned HOLD_CYCLES       = 4,
    parameter int unsigned SETTLE_CYCLES     = 16,
    parameter int unsigned DRAIN_TIMEOUT     = 255
) (
    input logic            clk_in,
    input logic            rst,
    lane_clk_ctrl_if.slave bus
);

    localparam int unsigned HS_MAX  = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_MAX = (HS_MAX > DRAIN_TIMEOUT) ? HS_MAX : DRAIN_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_INIT   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_INIT  = CNT_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, HOLD, SETTLE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             single_lane_q, single_lane_d;
    logic             pend_mode_q, pend_mode_d;
    logic             div_rst_n_q, div_rst_n_d;
    logic             tx_enable_q, tx_enable_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q       <= HOLD;
            cnt_q         <= HOLD_INIT;
            single_lane_q <= RESET_SINGLE_LANE;
            pend_mode_q   <= RESET_SINGLE_LANE;
            div_rst_n_q   <= 1'b0;
            tx_enable_q   <= 1'b0;
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            single_lane_q <= single_lane_d;
            pend_mode_q   <= pend_mode_d;
            div_rst_n_q   <= div_rst_n_d;
            tx_enable_q   <= tx_enable_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
        end
    end

    // Every output is a register. Each transition therefore loads the values
    // that the outputs must hold in the state being entered.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        single_lane_d = single_lane_q;
        pend_mode_d   = pend_mode_q;
        div_rst_n_d   = div_rst_n_q;
        tx_enable_d   = tx_enable_q;
        req_ready_d   = req_ready_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d     = SETTLE;
                    cnt_d       = SETTLE_INIT;
                    div_rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    tx_enable_d = 1'b1;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    if (bus.req_single_lane == single_lane_q) begin
                        done_d = 1'b1;
                    end else begin
                        pend_mode_d = bus.req_single_lane;
                        state_d     = DRAIN;
                        cnt_d       = DRAIN_INIT;
                        tx_enable_d = 1'b0;
                        req_ready_d = 1'b0;
                        busy_d      = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // When tx_idle and an expired count occur together, tx_idle
                // wins and the mode change goes ahead.
                if (bus.tx_idle) begin
                    state_d       = HOLD;
                    cnt_d         = HOLD_INIT;
                    single_lane_d = pend_mode_q;
                    div_rst_n_d   = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d     = IDLE;
                    tx_enable_d = 1'b1;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    timeout_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d     = HOLD;
                cnt_d       = HOLD_INIT;
                div_rst_n_d = 1'b0;
                tx_enable_d = 1'b0;
                req_ready_d = 1'b0;
                busy_d      = 1'b1;
            end
        endcase
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.tx_enable   = tx_enable_q;
    assign bus.single_lane = single_lane_q;
    assign bus.div_rst_n   = div_rst_n_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: doc/lane_clk_ctrl.md
Name: lane_clk_ctrl

Overview:
- Sequences lane-mode reconfiguration of the lane clock divider (single lane = clk/8, multi lane = clk/2).
- Accepts mode-change requests over a valid/ready handshake and quiesces the transmitter first (tx_enable low, waits for tx_idle).
- Holds the divider in reset while its mode input changes, waits for the divided clock to settle, then re-enables transmission.
- Sits between the link/config logic and clock_divider (drives its single_lane and rst_n inputs).

Parameters:
- RESET_SINGLE_LANE, 1, lane mode applied after reset (1 = single lane, 0 = multi lane).
- HOLD_CYCLES, 4, cycles div_rst_n is held low per reconfiguration; must be >= 1.
- SETTLE_CYCLES, 16, cycles waited after div_rst_n release before tx_enable; must be >= 1.
- DRAIN_TIMEOUT, 255, maximum DRAIN cycles waiting for tx_idle before abort; must be >= 1.

Ports:
- clk_in  in  1  system clock (same clock feeding the divider).
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  mode-change request valid.
- req_ready  out  1  controller can accept a request.
- req_single_lane  in  1  requested mode, sampled on the handshake.
- tx_idle  in  1  transmitter has no frame in flight.
- tx_enable  out  1  permits transmission.
- single_lane  out  1  registered mode to divider.
- div_rst_n  out  1  active-low reset to divider.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse: configuration complete or no-op acknowledged.
- timeout  out  1  one-cycle pulse: drain aborted.

Behaviour:
- All outputs are registered. A single down-counter cnt of width $clog2(max(HOLD_CYCLES, SETTLE_CYCLES, DRAIN_TIMEOUT) + 1) is shared across states.
- States: IDLE, DRAIN, HOLD, SETTLE.
- Reset values (asynchronous, while rst = 1):
  - state = HOLD, cnt = HOLD_CYCLES - 1
  - single_lane = RESET_SINGLE_LANE
  - div_rst_n = 0, tx_enable = 0, req_ready = 0, busy = 1, done = 0, timeout = 0
- Reset mid-operation discards any pending request and restarts the HOLD -> SETTLE boot sequence.
- HOLD:
  - div_rst_n = 0, tx_enable = 0.
  - Decrement cnt. At cnt == 0, go to SETTLE with cnt = SETTLE_CYCLES - 1 and div_rst_n = 1.
  - div_rst_n is low for exactly HOLD_CYCLES cycles.
- SETTLE:
  - div_rst_n = 1, tx_enable = 0.
  - Decrement cnt. At cnt == 0, go to IDLE. On entry to IDLE: tx_enable = 1, req_ready = 1, busy = 0, done = 1 for one cycle.
- IDLE:
  - req_ready = 1. A handshake is req_valid && req_ready.
  - If the handshake occurs with req_single_lane == single_lane: no-op. done pulses the next cycle, state stays IDLE, req_ready stays 1.
  - If the handshake occurs with req_single_lane != single_lane:
    - latch the new mode into pend_mode
    - next cycle: state = DRAIN, tx_enable = 0, req_ready = 0, busy = 1, cnt = DRAIN_TIMEOUT - 1
  - req_ready stays 0 in every non-IDLE state. req_valid outside IDLE is ignored; no queueing.
- DRAIN:
  - tx_idle == 1 → next cycle: state = HOLD, single_lane = pend_mode, div_rst_n = 0, cnt = HOLD_CYCLES - 1. Mode changes only while the divider is held in reset.
  - Otherwise, if cnt == 0 → abort:
    - return to IDLE with single_lane unchanged
    - tx_enable = 1, req_ready = 1
    - timeout pulses one cycle, done stays 0
  - Otherwise decrement cnt.
  - tx_idle and cnt == 0 in the same cycle: tx_idle wins (proceed to HOLD).
- Fixed latency, with the handshake at cycle T and tx_idle already 1:
  - DRAIN at T+1
  - div_rst_n low T+2 .. T+1+HOLD_CYCLES
  - done and tx_enable high at T+2+HOLD_CYCLES+SETTLE_CYCLES
- done and timeout are never high simultaneously. busy == (state != IDLE).

Test Plan:
- Reset with defaults:
  - Stimulus: rst pulse, then deassert at cycle 0.
  - Required: div_rst_n low cycles 0-3, high from cycle 4; tx_enable = 0 until done pulses at cycle 20; single_lane = 1 throughout.
- Switch to multi lane:
  - Stimulus: in IDLE, tx_idle = 1, handshake with req_single_lane = 0 at T.
  - Required: tx_enable falls at T+1; single_lane = 0 and div_rst_n = 0 at T+2 for 4 cycles; done and tx_enable high at T+22.
- No-op request:
  - Stimulus: handshake with req_single_lane == current mode.
  - Required: done at T+1; busy, tx_enable and div_rst_n unchanged; req_ready stays 1.
- Drain wait:
  - Stimulus: tx_idle = 0 for 10 cycles after handshake, then 1.
  - Required: HOLD entered one cycle after tx_idle rises; mode flips only then; no timeout.
- Drain timeout:
  - Stimulus: DRAIN_TIMEOUT = 8, tx_idle held 0.
  - Required: timeout pulse at T+9; single_lane unchanged; tx_enable = 1 and req_ready = 1 at T+9; done never pulses.
- Async reset mid-SETTLE:
  - Stimulus: rst asserted mid-cycle during SETTLE after a switch to multi lane.
  - Required: outputs return to reset values immediately (not at the next clock edge); single_lane = RESET_SINGLE_LANE; full boot sequence repeats.
